// File: rtl/spw_rx_fifo_credit_pkg.sv
// Shared constants, FCT FSM encoding and width helper for the SpaceWire RX FIFO.
package spw_fifo_pkg;

    // Default flow-control parameters (ECSS-E-ST-50-12C link layer)
    localparam int unsigned SPW_MAX_CREDIT = 56;
    localparam int unsigned SPW_FCT_CHUNK  = 8;

    // FCT request handshake states
    typedef enum logic [1:0] {
        FCT_IDLE   = 2'd0,
        FCT_REQ    = 2'd1,
        FCT_SETTLE = 2'd2
    } fct_state_e;

    // Ceiling log2, used to size the credit counter so MAX_CREDIT fits
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/spw_rx_fifo_credit_if.sv
// Host/receiver/TX-side signal bundle of the RX FIFO.
interface spw_rx_fifo_credit_if
    import spw_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = 9,
    parameter int unsigned AWIDTH = 6,
    parameter int unsigned CWIDTH = clog2(SPW_MAX_CREDIT + 1)
);
    logic              clear;
    logic              link_en;
    logic              wr_en;
    logic [DWIDTH-1:0] data_in;
    logic              rd_en;
    logic [DWIDTH-1:0] data_out;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic [AWIDTH:0]   count;
    logic [CWIDTH-1:0] credit;
    logic              fct_req;
    logic              fct_ack;
    logic              credit_error;

    // FIFO side
    modport slave (
        input  clear, link_en, wr_en, data_in, rd_en, fct_ack,
        output data_out, rd_valid, full, empty, count, credit, fct_req, credit_error
    );

    // Environment side (receiver, host, TX)
    modport master (
        output clear, link_en, wr_en, data_in, rd_en, fct_ack,
        input  data_out, rd_valid, full, empty, count, credit, fct_req, credit_error
    );
endinterface

// File: rtl/spw_rx_fifo_credit_mem_dp_sync.sv
// Simple dual-port RAM: synchronous write port, registered read port (read-first).
module mem_dp_sync #(
    parameter int unsigned DWIDTH = 9,
    parameter int unsigned AWIDTH = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [AWIDTH-1:0] i_wr_addr,
    input  logic [DWIDTH-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AWIDTH-1:0] i_rd_addr,
    output logic [DWIDTH-1:0] o_rd_data
);
    localparam int unsigned DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [DWIDTH-1:0] r_rd_data;

    // Write port; storage is never reset
    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read; returns the old word when the same slot is written (full FIFO)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/spw_rx_fifo_credit.sv
// SpaceWire RX FIFO with credit accounting and FCT request handshake.
module spw_rx_fifo_credit
    import spw_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH     = 9,
    parameter int unsigned AWIDTH     = 6,
    parameter int unsigned FCT_CHUNK  = SPW_FCT_CHUNK,
    parameter int unsigned MAX_CREDIT = SPW_MAX_CREDIT
) (
    input  logic                 clock,
    input  logic                 reset,
    spw_rx_fifo_credit_if.slave  bus
);
    localparam int unsigned       DEPTH      = 1 << AWIDTH;
    localparam int unsigned       CWIDTH     = clog2(MAX_CREDIT + 1);
    localparam logic [AWIDTH:0]   C_DEPTH    = (AWIDTH + 1)'(DEPTH);
    localparam logic [CWIDTH-1:0] C_CHUNK    = CWIDTH'(FCT_CHUNK);
    localparam logic [CWIDTH-1:0] C_CHUNK_M1 = CWIDTH'(FCT_CHUNK - 1);
    localparam logic [CWIDTH-1:0] C_ONE      = CWIDTH'(1);

    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_rd_ptr;
    logic [AWIDTH:0]   r_count;
    logic              r_full;
    logic              r_empty;
    logic [CWIDTH-1:0] r_credit;
    logic              r_credit_error;
    logic              r_rd_valid;
    fct_state_e        r_state;

    logic              w_wr;
    logic              w_rd;
    logic              w_ack;
    logic              w_eligible;
    logic [AWIDTH:0]   w_count_next;
    logic [CWIDTH-1:0] w_credit_next;
    fct_state_e        w_state_next;
    logic [DWIDTH-1:0] w_rd_data;

    // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it
    assign w_rd  = bus.rd_en && !r_empty;
    assign w_wr  = bus.wr_en && (!r_full || w_rd);
    // Ack only counts while the request is live; a dropped link abandons it
    assign w_ack = (r_state == FCT_REQ) && bus.fct_ack && bus.link_en;

    // Request another FCT only if the buffer can absorb the extra chunk and the credit cap holds
    assign w_eligible = ((32'(r_count) + 32'(r_credit) + FCT_CHUNK) <= DEPTH) &&
                        ((32'(r_credit) + FCT_CHUNK) <= MAX_CREDIT);

    // Occupancy and credit next-values
    always_comb begin
        w_count_next  = r_count;
        w_credit_next = r_credit;
        case ({w_wr, w_rd})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
        if (w_ack && w_wr) begin
            w_credit_next = r_credit + C_CHUNK_M1;
        end else if (w_ack) begin
            w_credit_next = r_credit + C_CHUNK;
        end else if (w_wr && (r_credit != '0)) begin
            w_credit_next = r_credit - C_ONE;
        end
    end

    // FCT request FSM next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FCT_IDLE: begin
                if (bus.link_en && w_eligible) begin
                    w_state_next = FCT_REQ;
                end
            end
            FCT_REQ: begin
                if (!bus.link_en) begin
                    w_state_next = FCT_IDLE;
                end else if (bus.fct_ack) begin
                    w_state_next = FCT_SETTLE;
                end
            end
            FCT_SETTLE: w_state_next = FCT_IDLE;
            default:    w_state_next = FCT_IDLE;
        endcase
    end

    // Pointers, flags, credit and FSM state; clear flushes everything but memory contents
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_credit       <= '0;
            r_credit_error <= 1'b0;
            r_rd_valid     <= 1'b0;
            r_state        <= FCT_IDLE;
        end else if (bus.clear) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_credit       <= '0;
            r_credit_error <= 1'b0;
            r_rd_valid     <= 1'b0;
            r_state        <= FCT_IDLE;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count    <= w_count_next;
            r_full     <= (w_count_next == C_DEPTH);
            r_empty    <= (w_count_next == '0);
            r_credit   <= w_credit_next;
            r_rd_valid <= w_rd;
            r_state    <= w_state_next;
            if (bus.wr_en && (r_credit == '0)) begin
                r_credit_error <= 1'b1;
            end
        end
    end

    mem_dp_sync #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clock     (clock),
        .reset     (reset),
        .i_wr_en   (w_wr && !bus.clear),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.data_in),
        .i_rd_en   (w_rd && !bus.clear),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    assign bus.data_out     = w_rd_data;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.count        = r_count;
    assign bus.credit       = r_credit;
    assign bus.fct_req      = (r_state == FCT_REQ);
    assign bus.credit_error = r_credit_error;
endmodule
